// File: rtl/fft_band_pkg.sv
// Shared band layout, scaler state encoding and bin-to-band lookup for the
// FFT band accumulator (band edges are laid out for a 1024-point FFT).
package fft_band_pkg;

    localparam int BAND_CNT  = 6;
    localparam int BAND_NONE = BAND_CNT;

    // Band k covers bins BAND_EDGE[k] .. BAND_EDGE[k+1]-1; DC and the upper half are excluded.
    localparam int BAND_EDGE [0:BAND_CNT]    = '{1, 4, 16, 48, 128, 256, 512};
    localparam int BAND_SHIFT [0:BAND_CNT-1] = '{6, 8, 9, 10, 11, 12};

    typedef enum logic [1:0] {
        SC_IDLE = 2'd0,
        SC_RUN  = 2'd1,
        SC_PUB  = 2'd2
    } sc_state_t;

    function automatic int band_of(input int idx);
        int b;
        b = BAND_NONE;
        for (int k = 0; k < BAND_CNT; k++) begin
            if (idx >= BAND_EDGE[k] && idx < BAND_EDGE[k+1]) begin
                b = k;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/fft_band_accumulator_band_scale_sat.sv
// Combinational right-shift of a band sum followed by saturation to the
// band output width; shared across all bands by the scaler.
module band_scale_sat #(
    parameter int ACC_W  = 24,
    parameter int BAND_W = 10
) (
    input  logic [ACC_W-1:0]  value,
    input  logic [4:0]        shift,
    output logic [BAND_W-1:0] scaled
);

    logic [ACC_W-1:0] shifted;

    assign shifted = value >> shift;
    assign scaled  = (|shifted[ACC_W-1:BAND_W]) ? {BAND_W{1'b1}} : shifted[BAND_W-1:0];

endmodule

// File: rtl/fft_band_accumulator.sv
// Sums FFT magnitude bins into log-spaced bands per frame, then scales,
// saturates and publishes all bands together with a one-cycle done pulse.
module fft_band_accumulator
    import fft_band_pkg::*;
#(
    parameter int FFT_LEN   = 1024,
    parameter int MAG_W     = 16,
    parameter int NUM_BANDS = 6,
    parameter int BAND_W    = 10,
    parameter int ACC_W     = 24
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        mag_tvalid,
    input  logic                        mag_tlast,
    input  logic [MAG_W-1:0]            mag_tdata,
    output logic [NUM_BANDS*BAND_W-1:0] bin_add,
    output logic                        done,
    output logic                        frame_err,
    output logic [7:0]                  bin_count
);

    localparam int IDX_W = $clog2(FFT_LEN);
    localparam int SEL_W = $clog2(NUM_BANDS);

    logic [IDX_W-1:0]  idx;
    logic [ACC_W-1:0]  acc    [NUM_BANDS];
    logic [ACC_W-1:0]  shadow [NUM_BANDS];
    logic [ACC_W-1:0]  addend [NUM_BANDS];
    logic [BAND_W-1:0] stage  [NUM_BANDS];
    logic [BAND_W-1:0] scaled;
    logic              beat;
    logic              last_bin;
    logic              good_end;
    logic              bad_end;
    logic              last_sel;
    int                bin_band;
    sc_state_t         state, state_n;
    logic [SEL_W-1:0]  sel, sel_n;

    assign beat     = mag_tvalid & enable;
    assign last_bin = (idx == IDX_W'(FFT_LEN - 1));
    assign good_end = beat & last_bin & mag_tlast;
    // Covers both an early tlast and a missing tlast on the final bin.
    assign bad_end  = beat & (last_bin != mag_tlast);
    assign last_sel = (sel == SEL_W'(NUM_BANDS - 1));

    always_comb begin
        bin_band = band_of(int'(idx));
        for (int k = 0; k < NUM_BANDS; k++) begin
            addend[k] = (bin_band == k) ? ACC_W'(mag_tdata) : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            frame_err <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                acc[k]    <= '0;
                shadow[k] <= '0;
            end
        end else begin
            frame_err <= bad_end;
            if (!enable || good_end || bad_end) begin
                idx <= '0;
                for (int k = 0; k < NUM_BANDS; k++) begin
                    acc[k] <= '0;
                end
            end else if (beat) begin
                idx <= idx + IDX_W'(1);
                for (int k = 0; k < NUM_BANDS; k++) begin
                    acc[k] <= acc[k] + addend[k];
                end
            end
            // The closing beat is folded into the snapshot so nothing is lost.
            if (good_end) begin
                for (int k = 0; k < NUM_BANDS; k++) begin
                    shadow[k] <= acc[k] + addend[k];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SC_IDLE;
            sel   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        case (state)
            SC_IDLE: begin
                if (good_end) begin
                    state_n = SC_RUN;
                    sel_n   = '0;
                end
            end
            SC_RUN: begin
                if (last_sel) begin
                    state_n = SC_PUB;
                end else begin
                    sel_n = sel + SEL_W'(1);
                end
            end
            SC_PUB:  state_n = SC_IDLE;
            default: state_n = SC_IDLE;
        endcase
    end

    band_scale_sat #(
        .ACC_W  (ACC_W),
        .BAND_W (BAND_W)
    ) u_scale (
        .value  (shadow[sel]),
        .shift  (5'(BAND_SHIFT[sel])),
        .scaled (scaled)
    );

    // The last band's result bypasses stage so bin_add and done land in the publish cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bin_add   <= '0;
            done      <= 1'b0;
            bin_count <= '0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                stage[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (state == SC_RUN) begin
                stage[sel] <= scaled;
                if (last_sel) begin
                    for (int k = 0; k < NUM_BANDS; k++) begin
                        bin_add[k*BAND_W +: BAND_W] <= (SEL_W'(k) == sel) ? scaled : stage[k];
                    end
                    done      <= 1'b1;
                    bin_count <= bin_count + 8'd1;
                end
            end
        end
    end

endmodule
